// File: rtl/ristretto_imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : ristretto_imem_responder
// Description : Instruction-memory responder with a fixed, parameterised
//               response latency. Accepts one fetch at a time, answers with
//               a one-cycle valid pulse carrying the addressed word, or an
//               error flag (with zero data) for misaligned / out-of-range
//               addresses. The word array is preloaded through a simple
//               write port that works in every state.
// Ports       : clk_i          - clock, rising edge
//               rstn_i         - asynchronous active-low reset
//               imem_req_i     - fetch request
//               imem_addr_i    - byte address of the fetch
//               imem_ready_o   - request can be accepted this cycle
//               imem_valid_o   - one-cycle response pulse
//               imem_rdata_o   - response data (held between pulses)
//               imem_err_o     - response is an error (only with valid)
//               stall_i        - forces imem_ready_o low
//               load_en_i      - preload write strobe
//               load_addr_i    - preload word index
//               load_data_i    - preload word
// Revision    : 1.0 - initial release
// ============================================================================
module ristretto_imem_responder #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32,
    parameter int MemWords  = 1024,
    parameter int Latency   = 1
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        imem_req_i,
    input  logic [AddrWidth-1:0]        imem_addr_i,
    output logic                        imem_ready_o,
    output logic                        imem_valid_o,
    output logic [DataWidth-1:0]        imem_rdata_o,
    output logic                        imem_err_o,
    input  logic                        stall_i,
    input  logic                        load_en_i,
    input  logic [$clog2(MemWords)-1:0] load_addr_i,
    input  logic [DataWidth-1:0]        load_data_i
);

    localparam int         c_idx_w    = $clog2(MemWords);
    localparam logic [3:0] c_cnt_load = 4'(Latency - 1);
    localparam bit         c_single   = (Latency == 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    // Elaboration-time parameter checks
    if (Latency < 1 || Latency > 15) begin : g_bad_latency
        $error("ristretto_imem_responder: Latency must be in 1..15");
    end
    if (MemWords < 2 || (MemWords & (MemWords - 1)) != 0) begin : g_bad_memwords
        $error("ristretto_imem_responder: MemWords must be a power of two >= 2");
    end

    logic [DataWidth-1:0] r_mem [MemWords];

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [3:0]           r_cnt;
    logic [AddrWidth-1:0] r_addr;
    logic                 r_err;
    logic [DataWidth-1:0] r_rdata;

    logic                 w_accept;
    logic [AddrWidth-1:0] w_sample_addr;
    logic                 w_misaligned;
    logic                 w_out_of_range;
    logic                 w_bad;
    logic                 w_enter_resp;

    assign w_accept = imem_req_i & imem_ready_o;

    // With Latency=1 the RESP-entry edge is the accept edge itself, so the
    // sample must come straight from the bus rather than the captured copy.
    assign w_sample_addr = w_accept ? imem_addr_i : r_addr;
    assign w_misaligned  = (w_sample_addr[1:0] != 2'b00);

    if (AddrWidth > c_idx_w + 2) begin : g_range_chk
        assign w_out_of_range = |w_sample_addr[AddrWidth-1:c_idx_w+2];
    end else begin : g_range_full
        assign w_out_of_range = 1'b0;
    end

    assign w_bad        = w_misaligned | w_out_of_range;
    assign w_enter_resp = (w_state_next == c_st_resp);

    // ---------------- State register ----------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- Next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_next = c_single ? c_st_resp : c_st_wait;
                end
            end
            c_st_wait: begin
                if (r_cnt == 4'd1) begin
                    w_state_next = c_st_resp;
                end
            end
            c_st_resp: begin
                if (w_accept) begin
                    w_state_next = c_single ? c_st_resp : c_st_wait;
                end else begin
                    w_state_next = c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // ---------------- Output logic ----------------
    always_comb begin
        imem_ready_o = (r_state != c_st_wait) & ~stall_i;
        imem_valid_o = (r_state == c_st_resp);
        imem_err_o   = r_err;
        imem_rdata_o = r_rdata;
    end

    // Latency down-counter and request address capture
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt  <= 4'd0;
            r_addr <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= imem_addr_i;
            end
            if (w_accept && !c_single) begin
                r_cnt <= c_cnt_load;
            end else if (r_state == c_st_wait) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Response datapath: sampled on the edge entering RESP. The array read
    // sees the pre-write contents when a preload hits the same word.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else if (w_enter_resp) begin
            r_err   <= w_bad;
            r_rdata <= w_bad ? '0 : r_mem[w_sample_addr[2 +: c_idx_w]];
        end else begin
            r_err   <= 1'b0;
        end
    end

    // Word array: never reset, so contents survive rstn_i
    always_ff @(posedge clk_i) begin
        if (load_en_i) begin
            r_mem[load_addr_i] <= load_data_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ristretto_imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ristretto_imem_responder
// Description : Self-checking bench for ristretto_imem_responder. Two
//               instances (Latency 1 and Latency 3) share one stimulus
//               stream; each is compared every cycle against a reference
//               model that tracks the outstanding request by the absolute
//               cycle number at which its response is due.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ristretto_imem_responder;

    localparam int C_MW = 16;
    localparam int C_IW = $clog2(C_MW);

    logic             clk;
    logic             rstn;
    logic             req;
    logic [31:0]      addr;
    logic             stall;
    logic             ld_en;
    logic [C_IW-1:0]  ld_addr;
    logic [31:0]      ld_data;

    logic [1:0]       rdy;
    logic [1:0]       vld;
    logic [1:0]       errs;
    logic [31:0]      rd0;
    logic [31:0]      rd1;

    ristretto_imem_responder #(
        .DataWidth (32),
        .AddrWidth (32),
        .MemWords  (C_MW),
        .Latency   (1)
    ) u_dut_l1 (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .imem_req_i   (req),
        .imem_addr_i  (addr),
        .imem_ready_o (rdy[0]),
        .imem_valid_o (vld[0]),
        .imem_rdata_o (rd0),
        .imem_err_o   (errs[0]),
        .stall_i      (stall),
        .load_en_i    (ld_en),
        .load_addr_i  (ld_addr),
        .load_data_i  (ld_data)
    );

    ristretto_imem_responder #(
        .DataWidth (32),
        .AddrWidth (32),
        .MemWords  (C_MW),
        .Latency   (3)
    ) u_dut_l3 (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .imem_req_i   (req),
        .imem_addr_i  (addr),
        .imem_ready_o (rdy[1]),
        .imem_valid_o (vld[1]),
        .imem_rdata_o (rd1),
        .imem_err_o   (errs[1]),
        .stall_i      (stall),
        .load_en_i    (ld_en),
        .load_addr_i  (ld_addr),
        .load_data_i  (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model state
    logic [31:0] m_mem   [C_MW];
    logic        m_busy  [2];
    int          m_due   [2];
    logic [31:0] m_addr  [2];
    logic        m_err   [2];
    logic [31:0] m_rdata [2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] rdata_of(input int d);
        return (d == 0) ? rd0 : rd1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d]  = 1'b0;
            m_due[d]   = 0;
            m_addr[d]  = '0;
            m_err[d]   = 1'b0;
            m_rdata[d] = '0;
        end
    endtask

    // Compare both DUTs for the current cycle, then advance the model over
    // the coming clock edge.
    task automatic eval_cycle();
        for (int d = 0; d < 2; d++) begin
            logic exp_v;
            logic exp_r;
            exp_v = m_busy[d] && (m_due[d] == cyc);
            exp_r = !stall && !(m_busy[d] && cyc < m_due[d]);
            check($sformatf("ready_l%0d", lat_of(d)), {31'b0, rdy[d]}, {31'b0, exp_r});
            check($sformatf("valid_l%0d", lat_of(d)), {31'b0, vld[d]}, {31'b0, exp_v});
            check($sformatf("err_l%0d", lat_of(d)), {31'b0, errs[d]}, {31'b0, exp_v & m_err[d]});
            check($sformatf("rdata_l%0d", lat_of(d)), rdata_of(d), m_rdata[d]);
            if (exp_v) m_busy[d] = 1'b0;
            if (req && exp_r) begin
                m_busy[d] = 1'b1;
                m_due[d]  = cyc + lat_of(d);
                m_addr[d] = addr;
            end
            // Response is sampled at the edge ending this cycle, before any
            // preload in this same cycle lands.
            if (m_busy[d] && m_due[d] == cyc + 1) begin
                if (m_addr[d][1:0] != 2'b00 || (m_addr[d] >> 2) >= 32'(C_MW)) begin
                    m_err[d]   = 1'b1;
                    m_rdata[d] = 32'h0;
                end else begin
                    m_err[d]   = 1'b0;
                    m_rdata[d] = m_mem[m_addr[d] >> 2];
                end
            end
        end
        if (ld_en) m_mem[ld_addr] = ld_data;
    endtask

    task automatic step(input logic rq, input logic [31:0] ad, input logic st,
                        input logic le, input logic [C_IW-1:0] la, input logic [31:0] ldd);
        req     = rq;
        addr    = ad;
        stall   = st;
        ld_en   = le;
        ld_addr = la;
        ld_data = ldd;
        @(negedge clk);
        eval_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {30'b0, vld}, 32'h0);
        check({tag, "_err"}, {30'b0, errs}, 32'h0);
        check({tag, "_rdata_l1"}, rd0, 32'h0);
        check({tag, "_rdata_l3"}, rd1, 32'h0);
    endtask

    initial begin
        rstn    = 1'b0;
        req     = 1'b0;
        addr    = '0;
        stall   = 1'b0;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        model_reset();
        for (int i = 0; i < C_MW; i++) m_mem[i] = 'x;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Preload every word
        step(1'b0, 0, 1'b0, 1'b1, 4'd0, 32'h0000_0013);
        step(1'b0, 0, 1'b0, 1'b1, 4'd1, 32'h00A0_0093);
        step(1'b0, 0, 1'b0, 1'b1, 4'd2, 32'hDEAD_BEEF);
        for (int i = 3; i < C_MW; i++) step(1'b0, 0, 1'b0, 1'b1, C_IW'(i), $urandom);

        // Back-to-back fetches of 0x0 then 0x4
        step(1'b1, 32'h0, 1'b0, 1'b0, '0, 0);
        step(1'b1, 32'h4, 1'b0, 1'b0, '0, 0);
        idle(4);

        // Single fetch of 0x8
        step(1'b1, 32'h8, 1'b0, 1'b0, '0, 0);
        idle(4);

        // Misaligned and out-of-range
        step(1'b1, 32'h6, 1'b0, 1'b0, '0, 0);
        idle(4);
        step(1'b1, 32'(C_MW * 4), 1'b0, 1'b0, '0, 0);
        idle(4);

        // Stalled request held, then released
        for (int i = 0; i < 4; i++) step(1'b1, 32'h4, 1'b1, 1'b0, '0, 0);
        step(1'b1, 32'h4, 1'b0, 1'b0, '0, 0);
        idle(4);

        // Preload colliding with the RESP-entry sample (Latency 3 alignment)
        step(1'b1, 32'h8, 1'b0, 1'b0, '0, 0);
        idle(1);
        step(1'b0, 0, 1'b0, 1'b1, 4'd2, 32'h1234_5678);
        idle(3);
        // Same collision aligned for Latency 1
        step(1'b1, 32'h8, 1'b0, 1'b1, 4'd2, 32'hCAFE_F00D);
        idle(4);
        step(1'b1, 32'h8, 1'b0, 1'b0, '0, 0);
        idle(4);

        // Reset asserted while the Latency-3 request sits in WAIT
        step(1'b1, 32'h4, 1'b0, 1'b0, '0, 0);
        step(1'b0, 0, 1'b0, 1'b0, '0, 0);
        req  = 1'b0;
        rstn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        idle(5);
        step(1'b1, 32'h4, 1'b0, 1'b0, '0, 0);
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            int          sel;
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      a = $urandom;
            else if (sel == 1) a = 32'($urandom_range(0, C_MW * 4 + 8));
            else               a = {28'(32'($urandom_range(0, C_MW + 1))), 2'b00};
            step(($urandom % 4) != 0, a, ($urandom % 5) == 0,
                 ($urandom % 4) == 0, C_IW'($urandom), $urandom);
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ristretto_imem_responder.md
RISTRETTO_IMEM_RESPONDER -- requirements
Module: ristretto_imem_responder

Interface
REQ-001 Parameter DataWidth, default 32, width of instruction data.
REQ-002 Parameter AddrWidth, default 32, width of byte address.
REQ-003 Parameter MemWords, default 1024, number of DataWidth-bit words stored; power of two, >=2.
REQ-004 Parameter Latency, default 1, number of cycles from accept to valid; legal range 1..15.
REQ-005 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006 rstn_i  in  1  reset; asynchronous, active-low.
REQ-007 imem_req_i  in  1  initiator requests a fetch at imem_addr_i.
REQ-008 imem_addr_i  in  AddrWidth  byte address of the requested instruction.
REQ-009 imem_ready_o  out  1  responder can accept a request this cycle.
REQ-010 imem_valid_o  out  1  one-cycle pulse; imem_rdata_o holds the response.
REQ-011 imem_rdata_o  out  DataWidth  response data.
REQ-012 imem_err_o  out  1  qualifies imem_valid_o; the access was misaligned or out of range.
REQ-013 stall_i  in  1  bench-driven busy injection; forces imem_ready_o low.
REQ-014 load_en_i  in  1  write strobe for memory preload.
REQ-015 load_addr_i  in  $clog2(MemWords)  word index to write.
REQ-016 load_data_i  in  DataWidth  word to write.

Function
REQ-017 The block SHALL accept a request in any cycle where imem_req_i & imem_ready_o = 1, and SHALL capture imem_addr_i in that cycle.
REQ-018 The FSM SHALL have exactly three states:
- IDLE: ready = ~stall_i.
- WAIT: ready = 0.
- RESP: ready = ~stall_i; valid = 1.
REQ-019 On accept, the FSM SHALL go to RESP if Latency = 1; otherwise it SHALL go to WAIT with a down-counter loaded to Latency-1.
REQ-020 In WAIT, the counter SHALL decrement each cycle; on the cycle the counter equals 1, the FSM SHALL go to RESP.
REQ-021 imem_valid_o SHALL rise exactly Latency cycles after the accept edge and SHALL stay high for exactly one cycle per accepted request.
REQ-022 In RESP with a new accept, the FSM SHALL go to RESP or WAIT per REQ-019, giving back-to-back throughput of one response per Latency cycles. In RESP without an accept, it SHALL go to IDLE.
REQ-023 At most one request SHALL be outstanding. Requests while ready = 0 SHALL be ignored, not queued.
REQ-024 Response data SHALL be mem[captured_addr[2+:$clog2(MemWords)]], sampled at the edge that enters RESP.
REQ-025 imem_rdata_o SHALL hold its last value while imem_valid_o = 0.
REQ-026 Misaligned access (captured_addr[1:0] != 0) SHALL give imem_err_o = 1 and imem_rdata_o = 0 in the RESP cycle.
REQ-027 Out-of-range access (captured_addr >> 2 >= MemWords) SHALL give imem_err_o = 1 and imem_rdata_o = 0 in the RESP cycle.
REQ-028 imem_err_o SHALL be 0 whenever imem_valid_o = 0.
REQ-029 load_en_i SHALL write mem[load_addr_i] at the clock edge, in any state.
REQ-030 If a load and the RESP-entry sample address the same word in the same cycle, the response SHALL return the pre-write data.
REQ-031 stall_i SHALL not affect WAIT counting or the RESP pulse of an already accepted request.
REQ-032 Latency outside 1..15 SHALL be rejected at elaboration.

Reset
REQ-033 On rstn_i low, the block SHALL immediately and asynchronously set:
- FSM = IDLE, counter = 0;
- imem_valid_o = 0, imem_err_o = 0, imem_rdata_o = 0.
REQ-034 Memory contents SHALL NOT be cleared by reset.
REQ-035 A request in flight when reset asserts SHALL be discarded; no valid pulse SHALL follow reset release.
REQ-036 imem_ready_o SHALL equal ~stall_i from the first cycle after reset release.

Verification
REQ-037 Latency=1, preload mem[0]=0x00000013, mem[1]=0x00A00093. Hold req with addr 0x0 then 0x4 on consecutive cycles -> valid on the next two cycles with rdata 0x00000013 then 0x00A00093; ready stays 1; err=0.
REQ-038 Latency=3, single req at addr 0x8 (mem[2]=0xDEADBEEF) -> ready=0 for 2 cycles; valid one cycle, exactly 3 cycles after accept, rdata=0xDEADBEEF.
REQ-039 Req at addr 0x6 -> valid with err=1, rdata=0. Req at addr MemWords*4 -> valid with err=1, rdata=0.
REQ-040 stall_i=1 with req held 4 cycles -> no accept and no valid. Deassert stall_i -> accept that cycle, then a single valid response.
REQ-041 Latency=3, accept, then pull rstn_i low in the WAIT state -> valid/err/rdata = 0 immediately; no valid after release; memory contents intact on the next read.
REQ-042 load_en_i to word 2 in the same cycle the RESP-entry sample reads word 2 -> old data returned; the next read of word 2 returns the new data.
